// File: rtl/ni_tx_packetizer.sv
// ni_tx_packetizer: header/size/payload packetizer with a credit-based router handshake and a payload skid FIFO.
// Define NI_TX_CHECKSUM_EN to append an XOR checksum flit and to send size+1 in the size flit.
module ni_tx_packetizer #(
    parameter int FLIT_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] target,
    input  logic [FLIT_WIDTH-1:0] size,
    output logic                  busy,
    output logic                  done,
    input  logic                  pl_valid,
    input  logic [FLIT_WIDTH-1:0] pl_data,
    output logic                  pl_ready,
    output logic                  tx,
    output logic [FLIT_WIDTH-1:0] data_out,
    input  logic                  credit_i
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {IDLE, HEADER, SIZE, PAYLOAD, CKSUM} state_t;
    state_t state, nxt;
    logic [ADDR_WIDTH-1:0] tgt;
    logic [FLIT_WIDTH-1:0] sz, remaining, accepted, size_flit, tail_flit;
    logic [FLIT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic xfer, push, pop, take;
    assign take = (state == IDLE) && start;
    assign xfer = tx && credit_i;
    assign pop = (state == PAYLOAD) && xfer;
    assign push = pl_valid && pl_ready;
    // count[AW] set means the FIFO holds exactly FIFO_DEPTH entries
    assign pl_ready = (state != IDLE) && !count[AW] && (accepted < sz);
`ifdef NI_TX_CHECKSUM_EN
    localparam state_t TAIL = CKSUM;
    logic [FLIT_WIDTH-1:0] cksum;
    always_ff @(posedge clock or negedge reset)
        if (!reset) cksum <= '0;
        else cksum <= take ? '0 : pop ? cksum ^ mem[rd_ptr] : cksum;
    assign size_flit = sz + FLIT_WIDTH'(1);
    assign tail_flit = cksum;
`else
    localparam state_t TAIL = IDLE;
    assign size_flit = sz;
    assign tail_flit = '0;
`endif
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            tgt <= '0;
            sz <= '0;
            remaining <= '0;
            accepted <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= nxt;
            busy <= nxt != IDLE;
            done <= (state != IDLE) && (nxt == IDLE);
            tgt <= take ? target : tgt;
            sz <= take ? size : sz;
            remaining <= take ? size : pop ? remaining - FLIT_WIDTH'(1) : remaining;
            accepted <= take ? '0 : push ? accepted + FLIT_WIDTH'(1) : accepted;
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clock)
        if (push) mem[wr_ptr] <= pl_data;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? HEADER : IDLE;
            HEADER:  nxt = xfer ? SIZE : HEADER;
            SIZE:    nxt = xfer ? ((sz != '0) ? PAYLOAD : TAIL) : SIZE;
            PAYLOAD: nxt = (xfer && remaining == FLIT_WIDTH'(1)) ? TAIL : PAYLOAD;
            CKSUM:   nxt = xfer ? IDLE : CKSUM;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        tx = (state == HEADER) || (state == SIZE) || (state == CKSUM) ||
             ((state == PAYLOAD) && (count != '0));
        data_out = (state == HEADER) ? FLIT_WIDTH'(tgt) :
                   (state == SIZE) ? size_flit :
                   (state == CKSUM) ? tail_flit :
                   ((state == PAYLOAD) && (count != '0)) ? mem[rd_ptr] : '0;
    end
endmodule

// File: tb/tb_ni_tx_packetizer.sv
// tb_ni_tx_packetizer: directed packets checked flit by flit against a bench-built expected stream.
module tb_ni_tx_packetizer;
    logic clock = 0, reset = 0, start = 0, pl_valid = 0, credit_i = 0;
    logic [7:0] target = 0;
    logic [15:0] size = 0, pl_data = 0;
    logic busy, done, pl_ready, tx;
    logic [15:0] data_out;
    int n_cmp = 0, n_err = 0, n_done, n_acc, cyc;
    bit rdy_seen;
    logic [15:0] pq[$], got[$], expq[$];

    ni_tx_packetizer dut (
        .clock(clock), .reset(reset), .start(start), .target(target), .size(size),
        .busy(busy), .done(done), .pl_valid(pl_valid), .pl_data(pl_data),
        .pl_ready(pl_ready), .tx(tx), .data_out(data_out), .credit_i(credit_i)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_pl();
        pl_valid = pq.size() > 0;
        pl_data = 16'h0;
        if (pl_valid) pl_data = pq[0];
    endtask

    // Samples the handshakes at the falling edge, then advances to just after the next rising edge
    task automatic tick();
        #4;
        if (tx && credit_i) got.push_back(data_out);
        if (pl_valid && pl_ready) begin
            n_acc++;
            void'(pq.pop_front());
        end
        if (pl_ready) rdy_seen = 1;
        if (done) begin
            n_done++;
            chk("busy_low_at_done", {31'b0, busy}, 0);
        end
        @(posedge clock);
        #1;
        drive_pl();
    endtask

    // mode 0: credit always high, 1: credit toggles, 2: credit low for 20 cycles after the header appears
    task automatic run_pkt(input logic [7:0] t, input logic [15:0] s, input int mode, input string tag);
        logic [15:0] x;
        got.delete();
        expq.delete();
        n_done = 0;
        n_acc = 0;
        rdy_seen = 0;
        x = 0;
        expq.push_back({8'h00, t});
`ifdef NI_TX_CHECKSUM_EN
        expq.push_back(s + 16'd1);
`else
        expq.push_back(s);
`endif
        foreach (pq[i]) begin
            expq.push_back(pq[i]);
            x ^= pq[i];
        end
`ifdef NI_TX_CHECKSUM_EN
        expq.push_back(x);
`endif
        credit_i = (mode != 2);
        start = 1;
        target = t;
        size = s;
        drive_pl();
        tick();
        start = 0;
        chk({tag, " hdr_tx"}, {31'b0, tx}, 1);
        chk({tag, " hdr_data"}, {16'b0, data_out}, {24'b0, t});
        chk({tag, " busy"}, {31'b0, busy}, 1);
        if (mode == 2) begin
            repeat (20) tick();
            chk({tag, " hold_tx"}, {31'b0, tx}, 1);
            chk({tag, " hold_data"}, {16'b0, data_out}, {24'b0, t});
            chk({tag, " hold_nothing_sent"}, got.size(), 0);
            chk({tag, " fifo_fill"}, n_acc, 8);
            chk({tag, " ready_full"}, {31'b0, pl_ready}, 0);
            credit_i = 1;
        end
        cyc = 0;
        while (n_done == 0 && cyc < 200) begin
            if (mode == 1) credit_i = ~credit_i;
            tick();
            cyc++;
        end
        chk({tag, " no_timeout"}, {31'b0, cyc < 200}, 1);
        repeat (2) tick();
        chk({tag, " done_once"}, n_done, 1);
        chk({tag, " busy_after"}, {31'b0, busy}, 0);
        chk({tag, " accepted"}, n_acc, s);
        chk({tag, " flit_count"}, got.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            chk($sformatf("%s flit%0d", tag, i), (i < got.size()) ? {16'b0, got[i]} : 32'hdead_beef, {16'b0, expq[i]});
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst tx", {31'b0, tx}, 0);
        chk("rst data", {16'b0, data_out}, 0);
        chk("rst busy", {31'b0, busy}, 0);
        chk("rst done", {31'b0, done}, 0);
        chk("rst ready", {31'b0, pl_ready}, 0);
        reset = 1;
        tick();

        pq = '{16'h00A1, 16'h00A2, 16'h00A3};
        run_pkt(8'h11, 16'd3, 0, "basic");

        pq.delete();
        run_pkt(8'h22, 16'd0, 0, "size0");
        chk("size0 ready_never", {31'b0, rdy_seen}, 0);

        pq.delete();
        for (int i = 0; i < 12; i++) pq.push_back(16'hC000 + 16'(i));
        run_pkt(8'h44, 16'd12, 2, "stall");

        pq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        run_pkt(8'h55, 16'd4, 1, "toggle");

        pq = '{16'h0E01, 16'h0E02, 16'h0E03, 16'h0E04, 16'h0E05};
        got.delete();
        credit_i = 1;
        start = 1;
        target = 8'h77;
        size = 16'd5;
        drive_pl();
        tick();
        start = 0;
        cyc = 0;
        while (got.size() < 4 && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("rstmid reached", got.size(), 4);
        reset = 0;
        #1;
        chk("rstmid tx", {31'b0, tx}, 0);
        chk("rstmid busy", {31'b0, busy}, 0);
        chk("rstmid ready", {31'b0, pl_ready}, 0);
        chk("rstmid data", {16'b0, data_out}, 0);
        pq.delete();
        drive_pl();
        @(posedge clock);
        #1;
        reset = 1;
        tick();
        pq = '{16'h00B1};
        run_pkt(8'h66, 16'd1, 0, "post_rst");

`ifdef NI_TX_CHECKSUM_EN
        pq = '{16'h00F0, 16'h0F0F};
        run_pkt(8'h33, 16'd2, 0, "cksum");
        chk("cksum size_flit", {16'b0, got[1]}, 32'h0003);
        chk("cksum tail", {16'b0, got[4]}, 32'h0FFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
